// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: single-outstanding imem requester
// feeding a 2-entry registered FIFO towards decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ins0_q, ins0_d;
    logic [31:0] pc0_q, pc0_d;
    logic [31:0] ins1_q, ins1_d;
    logic [31:0] pc1_q, pc1_d;
    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign pop     = instr_ready & (cnt_q != 2'd0);
    assign push    = (state_q == WAIT) & imem_rvalid & ~redirect;
    assign cnt_pop = cnt_q - {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        cnt_d      = cnt_q;
        ins0_d     = ins0_q;
        pc0_d      = pc0_q;
        ins1_d     = ins1_q;
        pc1_d      = pc1_q;
        if (redirect) begin
            // Flush only clears the count; pc holds the last head value.
            cnt_d      = 2'd0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            unique case (state_q)
                WAIT:    state_d = imem_rvalid ? REQ : DRAIN;
                DRAIN:   state_d = imem_rvalid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            cnt_d = cnt_pop + {1'b0, push};
            if (pop && cnt_q == 2'd2) begin
                ins0_d = ins1_q;
                pc0_d  = pc1_q;
            end
            if (push) begin
                if (cnt_pop == 2'd0) begin
                    ins0_d = imem_rdata;
                    pc0_d  = req_pc_q;
                end else begin
                    ins1_d = imem_rdata;
                    pc1_d  = req_pc_q;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (cnt_q != 2'd2) state_d = REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)
                        state_d = (cnt_d == 2'd2) ? IDLE : REQ;
                end
                DRAIN: begin
                    if (imem_rvalid) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            cnt_q      <= 2'd0;
            ins0_q     <= NOP_INSTR;
            pc0_q      <= RESET_PC;
            ins1_q     <= NOP_INSTR;
            pc1_q      <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            cnt_q      <= cnt_d;
            ins0_q     <= ins0_d;
            pc0_q      <= pc0_d;
            ins1_q     <= ins1_d;
            pc1_q      <= pc1_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (cnt_q != 2'd0);
    assign instr       = instr_valid ? ins0_q : NOP_INSTR;
    assign pc          = pc0_q;

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && cnt_pop == 2'd2)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;

    fetch_unit #(
        .RESET_PC (RST),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Reference model: fetch stream as a queue plus a few flags
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc, m_rpc, m_last;
    bit          m_req, m_out, m_drop;
    int          m_n0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_fpc  = RST;
            m_rpc  = RST;
            m_last = RST;
            m_req  = 1'b0;
            m_out  = 1'b0;
            m_drop = 1'b0;
        end else begin
            m_n0 = mq.size();
            if (redirect) begin
                mq.delete();
                m_fpc = {redirect_pc[31:2], 2'b00};
                if (m_out && !imem_rvalid) begin
                    m_drop = 1'b1;
                    m_req  = 1'b0;
                end else begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                    m_req  = 1'b1;
                end
            end else begin
                if (instr_ready && m_n0 > 0) void'(mq.pop_front());
                if (m_req) begin
                    if (imem_gnt) begin
                        m_rpc = m_fpc;
                        m_fpc = m_fpc + 32'd4;
                        m_out = 1'b1;
                        m_req = 1'b0;
                    end
                end else if (m_out) begin
                    if (imem_rvalid) begin
                        if (!m_drop)
                            mq.push_back(ent_t'{pc: m_rpc, ins: imem_rdata});
                        m_out  = 1'b0;
                        m_drop = 1'b0;
                        m_req  = (mq.size() < 2);
                    end
                end else begin
                    m_req = (m_n0 < 2);
                end
                if (mq.size() > 2) begin
                    errors++;
                    $display("FAIL model_overflow: size %0d", mq.size());
                end
            end
            if (mq.size() > 0) m_last = mq[0].pc;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("imem_req", 32'(imem_req), 32'(m_req));
            chk("imem_addr", imem_addr, m_fpc);
            chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
            chk("instr", instr, (mq.size() > 0) ? mq[0].ins : NOP);
            chk("pc", pc, m_last);
        end
    end

    // Memory: one outstanding request, response after lat extra cycles
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          lat = 0;

    task automatic drive(input bit g, input bit rd, input logic [31:0] rp,
                         input bit rdy, input bit arv);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (arv && mem_busy) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        redirect    = rd;
        redirect_pc = rp;
        instr_ready = rdy;
        imem_gnt    = g && !mem_busy;
        if (imem_req && imem_gnt && !rd) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_wait = lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic until_req(input int maxc);
        int n = 0;
        while (!imem_req && n < maxc) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        chk("req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic until_valid(input int maxc);
        int n = 0;
        while (!instr_valid && n < maxc) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        chk("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, RST);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_pc"}, pc, RST);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        rst_n = 1'b1;

        // First fetch: request at cycle 1, valid at cycle 3
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h100);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", instr, 32'h0050_0093);
        chk("c3_pc", pc, 32'h100);
        chk("c3_addr", imem_addr, 32'h104);

        // Backpressure: two entries then no request
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_pc", pc, 32'h100);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("bp_pop_pc", pc, 32'h104);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_req2", 32'(imem_req), 32'd1);
        chk("bp_addr2", imem_addr, 32'h108);
        repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_req3", 32'(imem_req), 32'd0);

        // Redirect while waiting for a slow response
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rw_addr", imem_addr, 32'h10C);
        lat = 2;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 32'h2003, 1'b1, 1'b1);
        lat = 0;
        chk("rw_drain_req", 32'(imem_req), 32'd0);
        chk("rw_drain_valid", 32'(instr_valid), 32'd0);
        until_req(8);
        chk("rw_target", imem_addr, 32'h2000);
        until_valid(8);
        chk("rw_pc", pc, 32'h2000);
        chk("rw_instr", instr, word(32'h2000));

        // Redirect in the same cycle as the response
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h3000, 1'b0, 1'b1);
        chk("sim_req", 32'(imem_req), 32'd1);
        chk("sim_addr", imem_addr, 32'h3000);
        chk("sim_valid", 32'(instr_valid), 32'd0);

        // Address wrap
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (6) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wr_pc0", pc, 32'hFFFF_FFFC);
        chk("wr_req", 32'(imem_req), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wr_pc1", pc, 32'h0);
        chk("wr_instr1", instr, word(32'h0));

        // Asynchronous reset mid-WAIT, late response ignored
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        until_req(5);
        lat = 3;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("arst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("late_valid", 32'(instr_valid), 32'd0);
        chk("late_addr", imem_addr, RST);
        lat = 0;
        until_valid(8);
        chk("late_pc", pc, 32'h100);
        chk("late_instr", instr, 32'h0050_0093);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(0, 3);
            drive(($urandom % 10) < 7, ($urandom % 20) == 0, $urandom,
                  ($urandom % 10) < 6, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
